// File: rtl/ch4_seq_ctrl.sv
// Channel-4 sequencing controller: 512 Hz frame sequencer, length counter,
// NR44 trigger handling and the channel-active / restart-pulse FSM.
module ch4_seq_ctrl #(
    parameter int RESTART_CYCLES = 4,
    parameter int LEN_BITS       = 6
) (
    input  logic                clk,
    input  logic                apu_reset,
    input  logic                div_tick_512,
    input  logic                wr_nr41,
    input  logic                wr_nr44,
    input  logic [7:0]          wdata,
    input  logic                dac_en,
    output logic                ch4_restart,
    output logic                ch4_active,
    output logic                len_en,
    output logic [2:0]          frame_step,
    output logic                len_tick,
    output logic                sweep_tick,
    output logic                env_tick,
    output logic [LEN_BITS:0]   len_remaining
);

    typedef enum logic [1:0] {
        OFF,
        RESTART,
        ON
    } state_t;

    localparam logic [LEN_BITS:0] LEN_FULL    = {1'b1, {LEN_BITS{1'b0}}};
    localparam logic [LEN_BITS:0] LEN_FULL_M1 = LEN_FULL - 1'b1;
    localparam logic [3:0]        PULSE_LOAD  = 4'(RESTART_CYCLES);

    state_t              state_q, state_d;
    logic [3:0]          pulse_q, pulse_d;
    logic                active_q, active_d;
    logic                len_en_q, len_en_d;
    logic [LEN_BITS:0]   len_q, len_d;
    logic [2:0]          step_q, step_d;

    logic                len_strobe;
    logic                sweep_strobe;
    logic                env_strobe;
    logic                expire;
    logic                trigger;

    always_comb begin
        len_strobe   = div_tick_512 & ~step_q[0];
        sweep_strobe = div_tick_512 & (step_q[1:0] == 2'b10);
        env_strobe   = div_tick_512 & (step_q == 3'd7);
    end

    // Length rules apply in order: tick decrement, NR41 load, then the NR44 quirks.
    always_comb begin
        state_d  = state_q;
        pulse_d  = pulse_q;
        active_d = active_q;
        len_en_d = len_en_q;
        len_d    = len_q;
        step_d   = step_q;
        expire   = 1'b0;
        trigger  = wr_nr44 & wdata[7];

        if (div_tick_512) begin
            step_d = step_q + 3'd1;
        end

        if (len_strobe && len_en_q && (len_q != '0)) begin
            len_d  = len_q - 1'b1;
            expire = (len_d == '0);
        end

        if (wr_nr41) begin
            len_d  = LEN_FULL - {1'b0, wdata[LEN_BITS-1:0]};
            expire = 1'b0;
        end

        if (wr_nr44) begin
            len_en_d = wdata[6];
            if (!len_en_q && wdata[6] && step_q[0] && (len_d != '0)) begin
                len_d = len_d - 1'b1;
                if ((len_d == '0) && !wdata[7]) begin
                    expire = 1'b1;
                end
            end
            if (trigger && (len_d == '0)) begin
                len_d = (wdata[6] && step_q[0]) ? LEN_FULL_M1 : LEN_FULL;
            end
        end

        if (trigger) begin
            state_d  = RESTART;
            pulse_d  = PULSE_LOAD;
            active_d = dac_en;
        end else begin
            if (expire || !dac_en) begin
                active_d = 1'b0;
            end
            case (state_q)
                OFF: begin
                end
                RESTART: begin
                    pulse_d = pulse_q - 4'd1;
                    if (pulse_q == 4'd1) begin
                        state_d = active_d ? ON : OFF;
                    end
                end
                ON: begin
                    if (!active_d) begin
                        state_d = OFF;
                    end
                end
                default: state_d = OFF;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (apu_reset) begin
            state_q  <= OFF;
            pulse_q  <= '0;
            active_q <= 1'b0;
            len_en_q <= 1'b0;
            len_q    <= '0;
            step_q   <= '0;
        end else begin
            state_q  <= state_d;
            pulse_q  <= pulse_d;
            active_q <= active_d;
            len_en_q <= len_en_d;
            len_q    <= len_d;
            step_q   <= step_d;
        end
    end

    // Reset masks every output combinationally so a pulse drops in the reset cycle itself.
    always_comb begin
        ch4_restart   = (state_q == RESTART) & ~apu_reset;
        ch4_active    = active_q & ~apu_reset;
        len_en        = len_en_q & ~apu_reset;
        frame_step    = apu_reset ? 3'd0 : step_q;
        len_tick      = len_strobe & ~apu_reset;
        sweep_tick    = sweep_strobe & ~apu_reset;
        env_tick      = env_strobe & ~apu_reset;
        len_remaining = apu_reset ? '0 : len_q;
    end

endmodule
